// File: rtl/control.sv
// Traffic-light sequencer for one approach: RED -> GREEN -> YELLOW -> RED,
// timed in blink beats, with traffic extension, pedestrian call and flashing-yellow maintenance.
`timescale 1ns/1ps
module control #(
  parameter int C_INT_RED        = 15,
  parameter int C_INT_GREEN      = 20,
  parameter int C_INT_YELLO      = 5,
  parameter int C_INT_PEDESTRIAN = 10
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       blink,
  input  logic       inMode,
  input  logic       inTraffic,
  input  logic       inPedestrian,
  output logic [1:0] outLight
);

  localparam logic [15:0] RED_N   = (C_INT_RED == 0)        ? 16'd1 : 16'(C_INT_RED);
  localparam logic [15:0] GREEN_N = (C_INT_GREEN == 0)      ? 16'd1 : 16'(C_INT_GREEN);
  localparam logic [15:0] YEL_N   = (C_INT_YELLO == 0)      ? 16'd1 : 16'(C_INT_YELLO);
  localparam logic [15:0] PED_N   = (C_INT_PEDESTRIAN == 0) ? 16'd1 : 16'(C_INT_PEDESTRIAN);
  // Hard cap kept one bit wider so a large green duration cannot wrap.
  localparam logic [16:0] GREEN_CAP = {GREEN_N, 1'b0};

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } stateT;

  stateT       state, stateNext;
  logic [15:0] count, countNext, cntInc;
  logic        pedLatch, pedNext;
  logic [1:0]  lightNext;

  logic [1:0]  blinkSr, modeSr, trafficSr, pedSr;
  logic        blinkPrev;
  logic        blinkS, modeS, trafficS, pedS, tick;

  assign blinkS   = blinkSr[1];
  assign modeS    = modeSr[1];
  assign trafficS = trafficSr[1];
  assign pedS     = pedSr[1];
  assign tick     = blinkS & ~blinkPrev;
  assign cntInc   = (count == 16'hFFFF) ? count : count + 16'd1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      blinkSr   <= 2'b00;
      modeSr    <= 2'b00;
      trafficSr <= 2'b00;
      pedSr     <= 2'b00;
      blinkPrev <= 1'b0;
    end else begin
      blinkSr   <= {blinkSr[0], blink};
      modeSr    <= {modeSr[0], inMode};
      trafficSr <= {trafficSr[0], inTraffic};
      pedSr     <= {pedSr[0], inPedestrian};
      blinkPrev <= blinkS;
    end
  end

  // Phase transitions only happen on the edge carrying a tick; maintenance mode overrides at once.
  always_comb begin
    stateNext = state;
    if (modeS) begin
      stateNext = FLASH;
    end else begin
      case (state)
        RED:    if (tick && cntInc >= RED_N) stateNext = GREEN;
        GREEN: begin
          if (tick) begin
            if (pedLatch && cntInc >= PED_N)            stateNext = YELLOW;
            else if (cntInc >= GREEN_N && !trafficS)    stateNext = YELLOW;
            else if ({1'b0, cntInc} >= GREEN_CAP)       stateNext = YELLOW;
          end
        end
        YELLOW: if (tick && cntInc >= YEL_N) stateNext = RED;
        FLASH:  stateNext = RED;
        default: stateNext = RED;
      endcase
    end
  end

  always_comb begin
    countNext = count;
    if (stateNext != state) countNext = 16'd0;
    else if (tick)          countNext = cntInc;

    pedNext = pedLatch;
    if (stateNext != state && (stateNext == RED || stateNext == FLASH)) pedNext = 1'b0;
    if (pedS && state != FLASH && stateNext != FLASH)                   pedNext = 1'b1;

    case (stateNext)
      RED:     lightNext = 2'b01;
      GREEN:   lightNext = 2'b10;
      YELLOW:  lightNext = 2'b11;
      FLASH:   lightNext = blinkS ? 2'b11 : 2'b00;
      default: lightNext = 2'b01;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= RED;
      count    <= 16'd0;
      pedLatch <= 1'b0;
      outLight <= 2'b01;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      pedLatch <= pedNext;
      outLight <= lightNext;
    end
  end

endmodule

// File: tb/tb_control.sv
// Directed bench for the traffic-light sequencer; the bench drives each blink beat
// itself, so every expected light code is known from the beat number.
`timescale 1ns/1ps
module tb_control;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       blink = 1'b0;
  logic       inMode = 1'b0;
  logic       inTraffic = 1'b0;
  logic       inPedestrian = 1'b0;
  logic [1:0] outLight;

  int passCnt = 0;
  int checkCnt = 0;

  control dut (
    .clk          (clk),
    .rstb         (rstb),
    .blink        (blink),
    .inMode       (inMode),
    .inTraffic    (inTraffic),
    .inPedestrian (inPedestrian),
    .outLight     (outLight)
  );

  always #5 clk = ~clk;

  // One beat = 20 clk: blink high for 10, low for 10; ends on a falling clk edge.
  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) blink = 1'b1;
      repeat (10) @(negedge clk);
      blink = 1'b0;
      repeat (9) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulsePed();
    @(negedge clk) inPedestrian = 1'b1;
    repeat (100) @(negedge clk);
    inPedestrian = 1'b0;
    idle(5);
  endtask

  task automatic chk(input string tag, input logic [1:0] expLight);
    checkCnt++;
    assert (outLight === expLight) passCnt++;
    else $error("FAIL %s: outLight=%b expected %b", tag, outLight, expLight);
  endtask

  initial begin
    // Reset held 200 ns
    idle(19);
    chk("reset_hold", 2'b01);
    @(negedge clk) rstb = 1'b1;
    idle(2);
    chk("reset_release", 2'b01);

    // Nominal cycle 15/20/5
    beats(14); chk("t1_red14", 2'b01);
    beats(1);  chk("t1_green", 2'b10);
    beats(19); chk("t1_green19", 2'b10);
    beats(1);  chk("t1_yellow", 2'b11);
    beats(4);  chk("t1_yellow4", 2'b11);
    beats(1);  chk("t1_red", 2'b01);

    // Traffic held through green: hard cap at 40 beats
    inTraffic = 1'b1;
    beats(15); chk("t2_green", 2'b10);
    beats(39); chk("t2_green39", 2'b10);
    beats(1);  chk("t2_cap", 2'b11);
    inTraffic = 1'b0;
    beats(5);  chk("t2_red", 2'b01);

    // Traffic drops at beat 25: yellow on the next tick
    inTraffic = 1'b1;
    beats(15);
    beats(25); chk("t3_green25", 2'b10);
    inTraffic = 1'b0;
    idle(5);   chk("t3_drop_no_tick", 2'b10);
    beats(1);  chk("t3_yellow", 2'b11);
    beats(5);  chk("t3_red", 2'b01);

    // Pedestrian pulse at beat 3 of green: yellow at beat 10
    beats(15);
    beats(3);
    pulsePed();
    chk("t4_ped_pending", 2'b10);
    beats(6);  chk("t4_green9", 2'b10);
    beats(1);  chk("t4_ped_exit", 2'b11);
    beats(5);  chk("t4_red", 2'b01);

    // Press during red is held: next green is 10 beats
    beats(5);
    pulsePed();
    beats(10); chk("t4b_green", 2'b10);
    beats(9);  chk("t4b_green9", 2'b10);
    beats(1);  chk("t4b_short_green", 2'b11);
    beats(5);  chk("t4b_red", 2'b01);

    // Maintenance mode mid-green
    beats(15);
    beats(5);
    inMode = 1'b1;
    idle(5);   chk("t5_flash_dark", 2'b00);
    blink = 1'b1;
    idle(6);   chk("t5_flash_on", 2'b11);
    blink = 1'b0;
    idle(6);   chk("t5_flash_off", 2'b00);
    blink = 1'b1;
    idle(6);   chk("t5_flash_on2", 2'b11);
    blink = 1'b0;
    idle(6);
    inMode = 1'b0;
    idle(5);   chk("t5_exit_red", 2'b01);
    beats(14); chk("t5_red14", 2'b01);
    beats(1);  chk("t5_green", 2'b10);

    // Async reset mid-yellow, with a pending pedestrian request that must be dropped
    beats(20); chk("t6_yellow", 2'b11);
    pulsePed();
    beats(1);  chk("t6_yellow1", 2'b11);
    rstb = 1'b0;
    #1;
    chk("t6_async_reset", 2'b01);
    idle(5);
    rstb = 1'b1;
    idle(2);
    beats(14); chk("t6_red14", 2'b01);
    beats(1);  chk("t6_green", 2'b10);
    beats(19); chk("t6_green19_latch_cleared", 2'b10);
    beats(1);  chk("t6_yellow_again", 2'b11);
    beats(5);  chk("t6_red", 2'b01);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
